// File: rtl/hex_digit_scanner.sv
// hex_digit_scanner
//   Time-multiplexed scan driver for a common-anode multi-digit 7-segment
//   display. A NUM_DIGITS*4-bit value is accepted into a one-entry pending
//   buffer through a valid/ready handshake. It is copied to the displayed
//   value only at frame boundaries, so a frame never mixes two values.
//   Each digit slot lasts DWELL cycles. The first BLANK cycles of a slot are
//   dead time with all anodes off. Optional leading-zero blanking is applied.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   new display value offered
//   in_data     in   display value, nibble i -> digit i (digit 0 = LS nibble)
//   in_ready    out  pending buffer empty, a value can be accepted
//   lzb         in   1 = blank leading zero digits (sampled every cycle)
//   hex         out  nibble of the current digit, registered
//   an          out  active-low anode enables, at most one bit low, registered
//   frame_tick  out  one-cycle pulse marking the last cycle of a scan frame
module hex_digit_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 1000,
    parameter int BLANK      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [4*NUM_DIGITS-1:0] in_data,
    output logic                    in_ready,
    input  logic                    lzb,
    output logic [3:0]              hex,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         shown_q, shown_d;
    logic [DW-1:0]         pend_q, pend_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [3:0]            hex_q, hex_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_tick_q, frame_tick_d;

    logic                  boundary;
    logic                  transfer;
    logic                  digit_blanked;
    logic [3:0]            nib [NUM_DIGITS];
    // lead_zero[i]: nibbles i..NUM_DIGITS-1 of the shown value are all zero.
    logic [NUM_DIGITS-1:0] lead_zero;

    assign in_ready = ~pend_valid_q;
    assign transfer = in_valid & ~pend_valid_q;
    assign boundary = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

    always_comb begin
        lead_zero = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib[i] = shown_q[4*i +: 4];
        end
        lead_zero[NUM_DIGITS-1] = (nib[NUM_DIGITS-1] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            lead_zero[i] = lead_zero[i+1] && (nib[i] == 4'h0);
        end
    end

    // Digit 0 always stays lit so that a zero value still shows "0".
    assign digit_blanked = lzb && (idx_q != '0) && lead_zero[idx_q];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        cnt_d        = cnt_q + CW'(1);
        idx_d        = idx_q;
        shown_d      = shown_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end

        // A boundary frees a full buffer; a transfer needs an empty one, so
        // the two can never act on pend in the same cycle.
        if (boundary && pend_valid_q) begin
            shown_d      = pend_q;
            pend_valid_d = 1'b0;
        end
        if (transfer) begin
            pend_d       = in_data;
            pend_valid_d = 1'b1;
        end

        frame_tick_d = boundary;
        hex_d        = nib[idx_q];
        an_d         = '1;
        if ((cnt_q >= CNT_BLANK) && !digit_blanked) begin
            an_d[idx_q] = 1'b0;
        end
    end

    // NOTE: the display and pending registers are reset too, because a reset must discard both values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shown_q      <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            hex_q        <= 4'h0;
            an_q         <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge state.
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shown_q      <= shown_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            hex_q        <= hex_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign hex        = hex_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_hex_digit_scanner.sv
// tb_hex_digit_scanner
//   Directed bench for hex_digit_scanner with NUM_DIGITS=4, DWELL=10,
//   BLANK=2. Cycle k counts rising edges after reset release. Outputs are
//   sampled on the falling edge after edge k, where they reflect the
//   scan position cnt=(k-1)%10, idx=((k-1)/10)%4. Frame boundaries fall on
//   edges 40, 80, 120, ... Expected values are hand-computed in the table.
module tb_hex_digit_scanner;

    localparam int ND    = 4;
    localparam int DWELL = 10;
    localparam int BLANK = 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [15:0]   in_data;
    logic          in_ready;
    logic          lzb;
    logic [3:0]    hex;
    logic [ND-1:0] an;
    logic          frame_tick;

    int checks;
    int errors;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [3:0] hex;
        logic       ft;
        logic       rdy;
    } vec_t;

    vec_t vecs[$];

    hex_digit_scanner #(
        .NUM_DIGITS(ND),
        .DWELL     (DWELL),
        .BLANK     (BLANK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .lzb       (lzb),
        .hex       (hex),
        .an        (an),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int cyc, input logic [3:0] e_an,
                         input logic [3:0] e_hex, input logic e_ft, input logic e_rdy);
        checks++;
        if (an !== e_an || hex !== e_hex || frame_tick !== e_ft || in_ready !== e_rdy) begin
            errors++;
            $display("FAIL %s cyc=%0d got an=%b hex=%h ft=%b rdy=%b want an=%b hex=%h ft=%b rdy=%b",
                     name, cyc, an, hex, frame_tick, in_ready, e_an, e_hex, e_ft, e_rdy);
        end
    endtask

    function automatic void add(input int cyc, input logic [3:0] a, input logic [3:0] h,
                                input logic ft, input logic rdy);
        vec_t v;
        v.cyc = cyc; v.an = a; v.hex = h; v.ft = ft; v.rdy = rdy;
        vecs.push_back(v);
    endfunction

    initial begin
        int vi;
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'h0;
        lzb      = 1'b0;

        // Scan test: reset idle, A5C3 load, blocked second offer, lzb, boundary transfer.
        add(1,   4'b1111, 4'h0, 0, 1);
        add(2,   4'b1111, 4'h0, 0, 1);
        add(3,   4'b1110, 4'h0, 0, 1);
        add(4,   4'b1110, 4'h0, 0, 1);
        add(5,   4'b1110, 4'h0, 0, 0);
        add(10,  4'b1110, 4'h0, 0, 0);
        add(11,  4'b1111, 4'h0, 0, 0);
        add(13,  4'b1101, 4'h0, 0, 0);
        add(23,  4'b1011, 4'h0, 0, 0);
        add(33,  4'b0111, 4'h0, 0, 0);
        add(39,  4'b0111, 4'h0, 0, 0);
        add(40,  4'b0111, 4'h0, 1, 1);
        add(41,  4'b1111, 4'h3, 0, 1);
        add(43,  4'b1110, 4'h3, 0, 1);
        add(46,  4'b1110, 4'h3, 0, 0);
        add(47,  4'b1110, 4'h3, 0, 0);
        add(53,  4'b1101, 4'hC, 0, 0);
        add(63,  4'b1011, 4'h5, 0, 0);
        add(73,  4'b0111, 4'hA, 0, 0);
        add(79,  4'b0111, 4'hA, 0, 0);
        add(80,  4'b0111, 4'hA, 1, 1);
        add(81,  4'b1111, 4'h4, 0, 0);
        add(83,  4'b1110, 4'h4, 0, 0);
        add(93,  4'b1101, 4'h3, 0, 0);
        add(113, 4'b0111, 4'h1, 0, 0);
        add(120, 4'b0111, 4'h1, 1, 1);
        add(123, 4'b1110, 4'h2, 0, 1);
        add(133, 4'b1101, 4'h4, 0, 1);
        add(143, 4'b1111, 4'h0, 0, 1);
        add(153, 4'b1111, 4'h0, 0, 1);
        add(156, 4'b0111, 4'h0, 0, 1);
        add(160, 4'b0111, 4'h0, 1, 0);
        add(163, 4'b1110, 4'h2, 0, 0);
        add(173, 4'b1101, 4'h4, 0, 0);
        add(193, 4'b1111, 4'h0, 0, 0);
        add(200, 4'b1111, 4'h0, 1, 1);
        add(203, 4'b1110, 4'h0, 0, 1);
        add(206, 4'b1110, 4'h0, 0, 0);
        add(213, 4'b1111, 4'h0, 0, 0);
        add(223, 4'b1011, 4'h0, 0, 0);
        add(240, 4'b0111, 4'h0, 1, 1);
        add(243, 4'b1110, 4'hF, 0, 1);
        add(246, 4'b1110, 4'hF, 0, 0);
        add(253, 4'b1101, 4'hF, 0, 0);
        add(265, 4'b1011, 4'hF, 0, 0);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        vi = 0;
        for (int k = 1; k <= 265; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (vi < vecs.size() && vecs[vi].cyc == k) begin
                check("scan", k, vecs[vi].an, vecs[vi].hex, vecs[vi].ft, vecs[vi].rdy);
                vi++;
            end
            // Stimulus for the next edge.
            case (k)
                4:   begin in_valid = 1'b1; in_data = 16'hA5C3; end
                5:   in_valid = 1'b0;
                45:  begin in_valid = 1'b1; in_data = 16'h1234; end
                46:  in_data = 16'h0042;      // held while pend is full
                81:  in_valid = 1'b0;
                110: lzb = 1'b1;
                155: lzb = 1'b0;
                159: begin in_valid = 1'b1; in_data = 16'h0000; end  // lands on edge 160
                160: in_valid = 1'b0;
                165: lzb = 1'b1;
                205: begin in_valid = 1'b1; in_data = 16'hFFFF; end
                206: in_valid = 1'b0;
                215: lzb = 1'b0;
                245: begin in_valid = 1'b1; in_data = 16'h1111; end
                246: in_valid = 1'b0;
                default: ;
            endcase
        end
        checks++;
        if (vi != vecs.size()) begin
            errors++;
            $display("FAIL table_coverage got %0d want %0d", vi, vecs.size());
        end

        // Asynchronous reset in slot 2 with 16'h1111 pending.
        rst_n = 1'b0;
        #1;
        check("async_reset", 0, 4'b1111, 4'h0, 0, 1);
        repeat (2) @(negedge clk);
        check("held_reset", 0, 4'b1111, 4'h0, 0, 1);
        rst_n = 1'b1;

        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            @(negedge clk);
            case (k)
                1:  check("rst_c1",  k, 4'b1111, 4'h0, 0, 1);
                3:  check("rst_c3",  k, 4'b1110, 4'h0, 0, 1);
                13: check("rst_c13", k, 4'b1101, 4'h0, 0, 1);
                40: check("rst_c40", k, 4'b0111, 4'h0, 1, 1);
                41: check("rst_c41", k, 4'b1111, 4'h0, 0, 1);
                43: check("rst_c43", k, 4'b1110, 4'h0, 0, 1);
                default: ;
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
